uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Oversampling UART receiver with a small receive FIFO. It is the line-side partner of the `TX` transmitter: it recovers 8N1 frames from `RXD` using a single system clock and 3-sample majority voting at mid-bit. Received bytes are buffered with a per-byte frame-error flag and presented on a first-word-fall-through read port. It replaces the separate `RXC` sampling clock with a `CLK`-derived bit counter, so TX and RX can share one clock domain.

## Interface
- `CLKS_PER_BIT`, default 16: `CLK` cycles per bit; legal range ≥ 4.
- `SIZE`, default 8: data bits per frame, LSB first.
- `DEPTH`, default 4: FIFO entries; power of 2.
- `CLK` in 1: the only clock; all logic on rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `RXD` in 1: serial line; idle high; asynchronous to `CLK`.
- `DQ` out `SIZE`: data of the FIFO head entry.
- `FRAME_ERROR` out 1: error flag of the FIFO head entry; stop bit sampled 0.
- `RX_VALID` out 1: FIFO not empty.
- `RX_READ` in 1: pop head; ignored when `RX_VALID`=0.
- `OVERRUN` out 1: sticky; a completed frame was dropped because the FIFO was full.
- `FIFO_COUNT` out clog2(`DEPTH`)+1: occupancy.

## Operation
- `RXD` passes through a 2-flop synchronizer (reset value 1) to give `rxs`. All decisions use `rxs`.
- The FSM has states WAIT_IDLE, IDLE, START, DATA, STOP. The reset state is WAIT_IDLE.
- **WAIT_IDLE**: go to IDLE on `rxs`=1.
- **IDLE**: go to START when `rxs`=0; clear the bit counter.
- **Bit counter**: runs 0..`CLKS_PER_BIT`-1, then wraps.
  - With H=`CLKS_PER_BIT`/2 (integer division), samples are taken at counts H-1, H and H+1.
  - The majority of the 3 samples becomes the bit value, decided at count H+1.
- **START**: a majority of 1 is a false start; go to IDLE with no push. A majority of 0 continues: at the counter wrap, go to DATA with bit index 0.
- **DATA**: at each decision, shift the bit into the MSB of the shift register (LSB-first framing). After `SIZE` bits, go to STOP at the counter wrap.
- **STOP**: the decision pushes {err = ~bit, data}. Next state:
  - bit=1: go to IDLE in the same cycle; do not wait for end of stop. This supports back-to-back frames.
  - bit=0: go to WAIT_IDLE.
- **Push when full**:
  - Without a simultaneous pop: drop the entry and set `OVERRUN`.
  - With a simultaneous pop: push and pop both occur, count is unchanged, `OVERRUN` is not set.
- `OVERRUN` clears on any accepted pop. Set and clear in the same cycle gives set.
- A pop when empty has no effect. A push and pop when empty cannot occur together, because the pop is ignored.

## Timing
- Reset values: `DQ`=0, `FRAME_ERROR`=0, `RX_VALID`=0, `OVERRUN`=0, `FIFO_COUNT`=0. The FSM resets to WAIT_IDLE and the pointers to 0.
- Reset asserted mid-frame aborts the frame and empties the FIFO. After release, the block needs `rxs`=1 before accepting a start.
- The start edge on `RXD` reaches `rxs` 2 cycles later.
- `RX_VALID` rises on the cycle after the stop-bit decision: about 2 + (`SIZE`+1)·`CLKS_PER_BIT` + H+2 cycles after the `RXD` falling edge.
- Read port:
  - `DQ` and `FRAME_ERROR` are valid whenever `RX_VALID`=1.
  - After a pop, the next entry appears the following cycle.
  - `RX_VALID` falls the cycle after the last pop.
- A single-cycle glitch on any one sample point is rejected by the majority vote.

## Structure
- Shared `uart_pkg` holds:
  - `uart_rx_state_t` enum {WAIT_IDLE, IDLE, START, DATA, STOP};
  - `UART_DEFAULT_CLKS_PER_BIT`=16;
  - `UART_DEFAULT_SIZE`=8.
- One sub-module, `uart_sync_fifo`:
  - parameters WIDTH and DEPTH;
  - ports push/pop/full/empty/count/head;
  - first-word fall-through.
- The FSM, counter, synchronizer and overrun logic live in the top module.

## Test plan
- **Single frame**: drive 0xA5 8N1 at `CLKS_PER_BIT`=16. Expect `RX_VALID`=1, `DQ`=0xA5, `FRAME_ERROR`=0, `FIFO_COUNT`=1. Pop, then expect `RX_VALID`=0.
- **False start**: `RXD` low for 3 cycles, then high. Expect no push and the FSM back in IDLE. Then send 0x3C and expect `DQ`=0x3C.
- **Frame error**: send 0x81 with stop bit 0, holding low for 2 more bit times. Expect `DQ`=0x81, `FRAME_ERROR`=1, and no further push until `RXD` returns high.
- **Overrun**: send 5 back-to-back frames 0x01..0x05 with no reads.
  - Expect `FIFO_COUNT`=4, `OVERRUN`=1, and pops returning 0x01..0x04.
  - `OVERRUN` clears on the first pop.
- **Full with simultaneous pop**: pulse `RX_READ` on the push cycle of the 5th frame. Expect no `OVERRUN`, count stays 4, and the 5th byte is retained.
- **Glitch and reset**:
  - 1-cycle inversion at count H of a data bit: the byte is received correctly.
  - `RESET` low mid-frame: outputs return to 0, FIFO is empty, and a subsequent clean 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default framing parameters
// and the 3-sample majority vote used for bit recovery.
package uart_pkg;

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      START,
      DATA,
      STOP
   } uart_rx_state_t;

   localparam int UART_DEFAULT_CLKS_PER_BIT = 16;
   localparam int UART_DEFAULT_SIZE         = 8;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Read-side bundle of the oversampling receiver: FWFT head entry, status and pop strobe.
interface uart_rx_os_if
   import uart_pkg::*;
#(
   parameter int SIZE  = UART_DEFAULT_SIZE,
   parameter int DEPTH = 4
);

   logic [SIZE-1:0]         DQ;
   logic                    FRAME_ERROR;
   logic                    RX_VALID;
   logic                    RX_READ;
   logic                    OVERRUN;
   logic [$clog2(DEPTH):0]  FIFO_COUNT;

   modport master (
      output DQ, FRAME_ERROR, RX_VALID, OVERRUN, FIFO_COUNT,
      input  RX_READ
   );

   modport slave (
      input  DQ, FRAME_ERROR, RX_VALID, OVERRUN, FIFO_COUNT,
      output RX_READ
   );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push while full is accepted only
// when a pop frees the head slot in the same cycle.
module uart_sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_push,
   input  logic [WIDTH-1:0]        i_data,
   input  logic                    i_pop,
   output logic                    o_full,
   output logic                    o_empty,
   output logic [$clog2(DEPTH):0]  o_count,
   output logic [WIDTH-1:0]        o_head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);

   // NOTE: storage has no reset; the head is masked to zero while empty instead.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver clocked from CLK: 2-flop synchronizer, bit counter with
// mid-bit 3-sample majority vote, and a FWFT receive FIFO with sticky overrun.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
   parameter int SIZE         = UART_DEFAULT_SIZE,
   parameter int DEPTH        = 4
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         RXD,
   uart_rx_os_if.master rx
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(SIZE + 1);
   localparam int NW = $clog2(DEPTH) + 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
   localparam logic [CW-1:0] CNT_S1   = CW'(H);
   localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);

   logic [1:0]      r_sync;
   uart_rx_state_t  r_state;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_samp;
   logic [BW-1:0]   r_bit_idx;
   logic [SIZE-1:0] r_shift;
   logic            r_push;
   logic [SIZE:0]   r_push_entry;
   logic            r_overrun;

   logic            w_rxs;
   logic            w_vote;
   logic            w_sample;
   logic            w_decide;
   logic            w_wrap;
   logic            w_full;
   logic            w_empty;
   logic            w_pop;
   logic [NW-1:0]   w_count;
   logic [SIZE:0]   w_head;

   // Idle-high reset value keeps a reset release from looking like a start edge.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) r_sync <= 2'b11;
      else        r_sync <= {r_sync[0], RXD};
   end

   assign w_rxs    = r_sync[1];
   assign w_sample = (r_cnt == CNT_S0) || (r_cnt == CNT_S1);
   assign w_decide = (r_cnt == CNT_DEC);
   assign w_wrap   = (r_cnt == CNT_LAST);
   assign w_vote   = maj3(r_samp[1], r_samp[0], w_rxs);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state      <= WAIT_IDLE;
         r_cnt        <= '0;
         r_samp       <= 2'b11;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_push       <= 1'b0;
         r_push_entry <= '0;
      end else begin
         // NOTE: defaults first; later nonblocking assignments in the case override them.
         r_push <= 1'b0;
         r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
         if (w_sample) r_samp <= {r_samp[0], w_rxs};
         case (r_state)
            WAIT_IDLE: begin
               r_cnt <= '0;
               if (w_rxs) r_state <= IDLE;
            end
            IDLE: begin
               r_cnt <= '0;
               if (!w_rxs) r_state <= START;
            end
            START: begin
               if (w_decide && w_vote) begin
                  r_state <= IDLE;
               end else if (w_wrap) begin
                  r_state   <= DATA;
                  r_bit_idx <= '0;
               end
            end
            DATA: begin
               if (w_decide) begin
                  r_shift   <= {w_vote, r_shift[SIZE-1:1]};
                  r_bit_idx <= r_bit_idx + 1'b1;
               end
               if (w_wrap && (r_bit_idx == BW'(SIZE))) r_state <= STOP;
            end
            STOP: begin
               // A good stop bit releases to IDLE early so back-to-back frames line up.
               if (w_decide) begin
                  r_push       <= 1'b1;
                  r_push_entry <= {~w_vote, r_shift};
                  r_state      <= w_vote ? IDLE : WAIT_IDLE;
               end
            end
            default: r_state <= WAIT_IDLE;
         endcase
      end
   end

   assign w_pop = rx.RX_READ & ~w_empty;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)                           r_overrun <= 1'b0;
      else if (r_push && w_full && !w_pop)  r_overrun <= 1'b1;
      else if (w_pop)                       r_overrun <= 1'b0;
   end

   uart_sync_fifo #(
      .WIDTH (SIZE + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (CLK),
      .rst_n   (RESET),
      .i_push  (r_push),
      .i_data  (r_push_entry),
      .i_pop   (rx.RX_READ),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count),
      .o_head  (w_head)
   );

   assign rx.DQ          = w_head[SIZE-1:0];
   assign rx.FRAME_ERROR = w_head[SIZE];
   assign rx.RX_VALID    = ~w_empty;
   assign rx.FIFO_COUNT  = w_count;
   assign rx.OVERRUN     = r_overrun;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: the driver queues {frame_error, data} per frame,
// the monitor pops the FIFO and compares against the queue head.
`timescale 1ns/1ps
module tb_uart_rx_os;

   localparam int CPB   = 16;
   localparam int SIZE  = 8;
   localparam int DEPTH = 4;
   // Cycles from the start-bit drive edge to the negedge before the FIFO write edge.
   localparam int PUSH_NEG = 157;

   logic        clk;
   logic        rst_n;
   logic        rxd;
   int          n_checks;
   int          n_pass;
   int unsigned cyc;
   int unsigned pop_cycle;
   bit          auto_read;
   logic [8:0]  exp_q[$];
   logic [8:0]  mon_exp;

   uart_rx_os_if #(.SIZE(SIZE), .DEPTH(DEPTH)) rx_if ();

   uart_rx_os #(
      .CLKS_PER_BIT (CPB),
      .SIZE         (SIZE),
      .DEPTH        (DEPTH)
   ) dut (
      .CLK   (clk),
      .RESET (rst_n),
      .RXD   (rxd),
      .rx    (rx_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one 8N1 frame; optional 1-cycle inversion on the count-H sample of glitch_bit.
   task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                             input int glitch_bit, input bit arm_pop);
      rxd = 1'b0;
      if (arm_pop) pop_cycle = cyc + PUSH_NEG;
      tick(CPB);
      for (int b = 0; b < SIZE; b++) begin
         rxd = data[b];
         if (b == glitch_bit) begin
            tick(9);
            rxd = ~data[b];
            tick(1);
            rxd = data[b];
            tick(CPB - 10);
         end else begin
            tick(CPB);
         end
      end
      rxd = stop_bit;
      tick(CPB);
      pop_cycle = 32'hFFFF_FFFF;
   endtask

   task automatic pop_one();
      pop_cycle = cyc;
      tick(1);
      pop_cycle = 32'hFFFF_FFFF;
      tick(1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || rx_if.RX_VALID) && n < 400) begin
         tick(1);
         n++;
      end
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   // Monitor: sole driver of RX_READ; pops and scores whenever reading is enabled.
   initial begin
      rx_if.RX_READ = 1'b0;
      forever begin
         @(negedge clk);
         rx_if.RX_READ = 1'b0;
         if (rx_if.RX_VALID && (auto_read || cyc == pop_cycle)) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_byte: got %0h with nothing expected", {rx_if.FRAME_ERROR, rx_if.DQ});
            end else begin
               mon_exp = exp_q.pop_front();
               check("rx_byte", {rx_if.FRAME_ERROR, rx_if.DQ}, mon_exp);
            end
            rx_if.RX_READ = 1'b1;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      pop_cycle = 32'hFFFF_FFFF;
      rst_n     = 1'b0;
      rxd       = 1'b1;
      tick(3);
      check("rst_rx_valid", rx_if.RX_VALID, 0);
      check("rst_count", rx_if.FIFO_COUNT, 0);
      check("rst_dq", rx_if.DQ, 0);
      check("rst_frame_error", rx_if.FRAME_ERROR, 0);
      check("rst_overrun", rx_if.OVERRUN, 0);
      rst_n = 1'b1;
      tick(4);

      // Single frame
      exp_q.push_back({1'b0, 8'hA5});
      send_frame(8'hA5, 1'b1, -1, 1'b0);
      tick(4);
      check("a5_valid", rx_if.RX_VALID, 1);
      check("a5_count", rx_if.FIFO_COUNT, 1);
      check("a5_dq", rx_if.DQ, 8'hA5);
      pop_one();
      check("a5_valid_after_pop", rx_if.RX_VALID, 0);

      // False start, then a real frame
      rxd = 1'b0;
      tick(3);
      rxd = 1'b1;
      tick(2 * CPB);
      check("false_start_count", rx_if.FIFO_COUNT, 0);
      exp_q.push_back({1'b0, 8'h3C});
      send_frame(8'h3C, 1'b1, -1, 1'b0);
      tick(4);
      check("3c_count", rx_if.FIFO_COUNT, 1);
      pop_one();

      // Frame error: stop low, line held low two more bit times
      exp_q.push_back({1'b1, 8'h81});
      send_frame(8'h81, 1'b0, -1, 1'b0);
      tick(2 * CPB);
      rxd = 1'b1;
      tick(CPB);
      check("ferr_count", rx_if.FIFO_COUNT, 1);
      check("ferr_flag", rx_if.FRAME_ERROR, 1);
      pop_one();
      check("ferr_valid_after_pop", rx_if.RX_VALID, 0);

      // Overrun: five back-to-back frames, no reads; the fifth is dropped
      for (int i = 1; i <= 5; i++) begin
         if (i <= DEPTH) exp_q.push_back({1'b0, 8'(i)});
         send_frame(8'(i), 1'b1, -1, 1'b0);
      end
      tick(4);
      check("ovr_count_full", rx_if.FIFO_COUNT, 4);
      check("ovr_set", rx_if.OVERRUN, 1);
      pop_one();
      check("ovr_cleared_by_pop", rx_if.OVERRUN, 0);
      check("ovr_count_after_pop", rx_if.FIFO_COUNT, 3);
      auto_read = 1'b1;
      wait_drain();
      auto_read = 1'b0;

      // Full with a pop on the push cycle of the fifth frame
      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back({1'b0, 8'(i * 8'h11)});
         send_frame(8'(i * 8'h11), 1'b1, -1, 1'b0);
      end
      exp_q.push_back({1'b0, 8'h55});
      send_frame(8'h55, 1'b1, -1, 1'b1);
      tick(4);
      check("simpop_no_overrun", rx_if.OVERRUN, 0);
      check("simpop_count", rx_if.FIFO_COUNT, 4);
      auto_read = 1'b1;
      wait_drain();

      // Glitch on the count-H sample of data bit 3
      exp_q.push_back({1'b0, 8'hC3});
      send_frame(8'hC3, 1'b1, 3, 1'b0);
      wait_drain();
      auto_read = 1'b0;

      // Reset mid-frame with one byte buffered
      exp_q.push_back({1'b0, 8'h99});
      send_frame(8'h99, 1'b1, -1, 1'b0);
      tick(4);
      check("prereset_count", rx_if.FIFO_COUNT, 1);
      rxd = 1'b0;
      tick(CPB);
      rxd = 1'b1;
      tick(CPB + CPB / 2);
      rst_n = 1'b0;
      exp_q.delete();
      rxd = 1'b1;
      tick(2);
      check("midrst_valid", rx_if.RX_VALID, 0);
      check("midrst_count", rx_if.FIFO_COUNT, 0);
      check("midrst_dq", rx_if.DQ, 0);
      check("midrst_frame_error", rx_if.FRAME_ERROR, 0);
      rst_n = 1'b1;
      tick(CPB);
      check("postrst_count", rx_if.FIFO_COUNT, 0);
      exp_q.push_back({1'b0, 8'h5A});
      auto_read = 1'b1;
      send_frame(8'h5A, 1'b1, -1, 1'b0);
      wait_drain();
      auto_read = 1'b0;
      tick(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
